// File: rtl/icache_thread_arbiter.sv
// Round-robin arbiter sharing one read-only instruction cache between SMT
// fetch threads. A thread that misses becomes the owner and holds the cache
// until its refill resolves. Responses are steered to the owner only.
module icache_thread_arbiter #(
  parameter int NUM_THREADS   = 2,
  parameter int TID_WIDTH     = 1,
  parameter int ADDRESS_WIDTH = 22,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                 i_Clk,
  input  logic                                 i_Reset_n,
  input  logic [NUM_THREADS-1:0]               i_Thr_Valid,
  input  logic [NUM_THREADS*ADDRESS_WIDTH-1:0] i_Thr_Address,
  input  logic [NUM_THREADS-1:0]               i_Thr_Kill,
  output logic [NUM_THREADS-1:0]               o_Thr_Valid,
  output logic [TID_WIDTH-1:0]                 o_Thr_ID,
  output logic [4*DATA_WIDTH-1:0]              o_Thr_Data,
  output logic                                 o_IC_Valid,
  output logic [ADDRESS_WIDTH-1:0]             o_IC_Address,
  input  logic                                 i_IC_Ready,
  input  logic                                 i_IC_Valid,
  input  logic [4*DATA_WIDTH-1:0]              i_IC_Data,
  output logic [15:0]                          o_Miss_Count
);

  typedef enum logic {
    ARB  = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [TID_WIDTH-1:0]       ptr_q, ptr_d;
  logic [TID_WIDTH-1:0]       owner_q, owner_d;
  logic [ADDRESS_WIDTH-1:0]   owner_addr_q, owner_addr_d;
  logic                       delivered_q, delivered_d;
  logic [15:0]                miss_count_q, miss_count_d;

  logic [NUM_THREADS-1:0]     eligible_s;
  logic                       win_found_s;
  logic [TID_WIDTH-1:0]       win_tid_s;
  logic [ADDRESS_WIDTH-1:0]   win_addr_s;
  logic                       done_s;

  logic [NUM_THREADS-1:0]     thr_valid_s;
  logic [TID_WIDTH-1:0]       thr_id_s;
  logic                       ic_valid_s;
  logic [ADDRESS_WIDTH-1:0]   ic_addr_s;

  // Thread id following t in rotation order, wrapping at NUM_THREADS.
  function automatic logic [TID_WIDTH-1:0] next_tid(input logic [TID_WIDTH-1:0] t);
    if (t == TID_WIDTH'(NUM_THREADS - 1)) begin
      next_tid = '0;
    end else begin
      next_tid = t + TID_WIDTH'(1'b1);
    end
  endfunction

  assign eligible_s = i_Thr_Valid & ~i_Thr_Kill;

  // Round-robin winner search starting at the pointer, first eligible wins.
  always_comb begin
    logic [TID_WIDTH:0] cand;
    win_found_s = 1'b0;
    win_tid_s   = ptr_q;
    cand        = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      cand = {1'b0, ptr_q} + (TID_WIDTH+1)'(i);
      if (cand >= (TID_WIDTH+1)'(NUM_THREADS)) begin
        cand = cand - (TID_WIDTH+1)'(NUM_THREADS);
      end else begin
        cand = cand;
      end
      if (!win_found_s && eligible_s[cand[TID_WIDTH-1:0]]) begin
        win_found_s = 1'b1;
        win_tid_s   = cand[TID_WIDTH-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign win_addr_s = i_Thr_Address[int'(win_tid_s)*ADDRESS_WIDTH +: ADDRESS_WIDTH];

  // Next-state, cache request and response steering for ARB and MISS.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    owner_addr_d = owner_addr_q;
    delivered_d  = delivered_q;
    miss_count_d = miss_count_q;
    thr_valid_s  = '0;
    thr_id_s     = win_tid_s;
    ic_valid_s   = 1'b0;
    ic_addr_s    = win_addr_s;
    done_s       = 1'b0;
    case (state_q)
      ARB: begin
        if (win_found_s) begin
          ic_valid_s = 1'b1;
          if (i_IC_Ready && i_IC_Valid) begin
            thr_valid_s[win_tid_s] = 1'b1;
            ptr_d                  = next_tid(win_tid_s);
          end else if (i_IC_Ready) begin
            state_d      = MISS;
            owner_d      = win_tid_s;
            owner_addr_d = win_addr_s;
            delivered_d  = 1'b0;
            if (miss_count_q != 16'hFFFF) begin
              miss_count_d = miss_count_q + 16'd1;
            end else begin
              miss_count_d = miss_count_q;
            end
          end else begin
            state_d = ARB;
          end
        end else begin
          state_d = ARB;
        end
      end
      MISS: begin
        ic_valid_s = 1'b1;
        ic_addr_s  = owner_addr_q;
        thr_id_s   = owner_q;
        if (i_IC_Valid) begin
          thr_valid_s[owner_q] = i_Thr_Valid[owner_q] & ~i_Thr_Kill[owner_q];
        end else begin
          thr_valid_s = '0;
        end
        // A kill counts as resolved: the owner has nothing left to collect.
        done_s      = delivered_q | i_IC_Valid | i_Thr_Kill[owner_q];
        delivered_d = done_s;
        if (i_IC_Ready) begin
          state_d = ARB;
          ptr_d   = done_s ? next_tid(owner_q) : owner_q;
        end else begin
          state_d = MISS;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State, rotation pointer, owner context and miss counter.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= ARB;
      ptr_q        <= '0;
      owner_q      <= '0;
      owner_addr_q <= '0;
      delivered_q  <= 1'b0;
      miss_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      owner_addr_q <= owner_addr_d;
      delivered_q  <= delivered_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Hit responses are zero-latency, so outputs are combinational; reset
  // forces them low immediately even while requests are still asserted.
  assign o_Thr_Valid  = thr_valid_s & {NUM_THREADS{i_Reset_n}};
  assign o_Thr_ID     = thr_id_s & {TID_WIDTH{i_Reset_n}};
  assign o_Thr_Data   = i_IC_Data & {(4*DATA_WIDTH){i_Reset_n}};
  assign o_IC_Valid   = ic_valid_s & i_Reset_n;
  assign o_IC_Address = ic_addr_s & {ADDRESS_WIDTH{i_Reset_n}};
  assign o_Miss_Count = miss_count_q;

endmodule
